// File: rtl/multicycle_control_pkg.sv
// Shared constants for the multicycle RISC-V control unit.
//   - FSM state codes (4-bit, debug-visible on the state output)
//   - major opcodes decoded in DECODE / MEM_ADDR
//   - ALUControl and ALUSrcB select encodings
//   - opcode_legal(): true for the five opcodes the control unit executes
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_PC_INC    = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    function automatic logic opcode_legal(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH: return 1'b1;
            default:                                          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// R-type function decode for the multicycle control unit.
// Ports:
//   funct3     in  3  IR[14:12]
//   funct7b5   in  1  IR[30]
//   ALUControl out 4  ALU operation (ADD for any unsupported code)
//   illegal    out 1  {funct7b5,funct3} is not a supported R-type operation
module alu_decoder
    import multicycle_control_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [3:0] ALUControl,
    output logic       illegal
);

    always_comb begin
        ALUControl = ALU_ADD;
        illegal    = 1'b0;
        casez ({funct7b5, funct3})
            4'b0000: ALUControl = ALU_ADD;
            4'b1000: ALUControl = ALU_SUB;
            4'b?111: ALUControl = ALU_AND;
            4'b?110: ALUControl = ALU_OR;
            default: illegal    = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Control FSM for a multicycle RISC-V datapath (lw, sw, R-type, addi, beq).
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   opcode, funct3, funct7b5   instruction fields from IR
//   zero                       ALU zero flag (used only in BRANCH)
//   PCWrite .. regWrite        1-bit datapath controls
//   ALUSrcB                    00 B, 01 const 4, 10 imm
//   ALUControl                 0000 AND, 0001 OR, 0010 ADD, 0110 SUB
//   illegal_op                 unsupported opcode (DECODE) or funct (EXEC_R)
//   state                      current state register (debug)
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       PCWrite,
    output logic       IorD,
    output logic       memRead,
    output logic       memWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       PCSource,
    output logic       ALUSrcA,
    output logic       regWrite,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUControl,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_t     state_q;
    state_t     state_d;
    // Remembers an unsupported funct seen in EXEC_R so ALU_WB can drop the
    // register write while staying a function of registered state only.
    logic       funct_bad_q;

    logic [3:0] dec_alu_control;
    logic       dec_illegal;

    logic       pc_write_moore;
    logic       in_branch;
    logic       mem_read_c;
    logic       mem_write_c;
    logic       ir_write_c;
    logic       reg_write_c;
    logic       illegal_c;

    alu_decoder u_alu_decoder (
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .ALUControl (dec_alu_control),
        .illegal    (dec_illegal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_FETCH;
            funct_bad_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            funct_bad_q <= (state_q == S_EXEC_R) && dec_illegal;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
                    OP_RTYPE:          state_d = S_EXEC_R;
                    OP_ITYPE:          state_d = S_EXEC_I;
                    OP_BRANCH:         state_d = S_BRANCH;
                    default:           state_d = S_PC_INC;
                endcase
            end
            S_MEM_ADDR: state_d = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ: state_d = S_MEM_WB;
            S_EXEC_R:   state_d = S_ALU_WB;
            S_EXEC_I:   state_d = S_ALU_WB;
            S_BRANCH:   state_d = zero ? S_FETCH : S_PC_INC;
            default:    state_d = S_FETCH;
        endcase
    end

    // PCWrite in BRANCH is kept out of this block (see assign below) so that
    // zero never feeds the ALU-select outputs, avoiding a false comb loop
    // through the datapath ALU.
    always_comb begin
        pc_write_moore = 1'b0;
        in_branch      = 1'b0;
        IorD           = 1'b0;
        mem_read_c     = 1'b0;
        mem_write_c    = 1'b0;
        MemtoReg       = 1'b0;
        ir_write_c     = 1'b0;
        PCSource       = 1'b0;
        ALUSrcA        = 1'b0;
        reg_write_c    = 1'b0;
        ALUSrcB        = SRCB_REG;
        ALUControl     = ALU_ADD;
        illegal_c      = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read_c = 1'b1;
                ir_write_c = 1'b1;
            end
            S_DECODE: begin
                ALUSrcB   = SRCB_IMM;
                illegal_c = !opcode_legal(opcode);
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEM_READ: begin
                mem_read_c = 1'b1;
                IorD       = 1'b1;
            end
            S_MEM_WB: begin
                MemtoReg       = 1'b1;
                reg_write_c    = 1'b1;
                ALUSrcB        = SRCB_FOUR;
                pc_write_moore = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write_c    = 1'b1;
                IorD           = 1'b1;
                ALUSrcB        = SRCB_FOUR;
                pc_write_moore = 1'b1;
            end
            S_EXEC_R: begin
                ALUSrcA    = 1'b1;
                ALUControl = dec_alu_control;
                illegal_c  = dec_illegal;
            end
            S_EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_ALU_WB: begin
                reg_write_c    = !funct_bad_q;
                ALUSrcB        = SRCB_FOUR;
                pc_write_moore = 1'b1;
            end
            S_BRANCH: begin
                in_branch  = 1'b1;
                ALUSrcA    = 1'b1;
                ALUControl = ALU_SUB;
                PCSource   = 1'b1;
            end
            S_PC_INC: begin
                ALUSrcB        = SRCB_FOUR;
                pc_write_moore = 1'b1;
            end
            default: ;
        endcase
    end

    assign PCWrite    = !reset && (in_branch ? zero : pc_write_moore);
    assign memRead    = !reset && mem_read_c;
    assign memWrite   = !reset && mem_write_c;
    assign IRWrite    = !reset && ir_write_c;
    assign regWrite   = !reset && reg_write_c;
    assign illegal_op = !reset && illegal_c;
    assign state      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    localparam logic [3:0] ADD = 4'b0010;
    localparam logic [3:0] SUB = 4'b0110;
    localparam logic [3:0] AND = 4'b0000;
    localparam logic [3:0] OR  = 4'b0001;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       PCWrite, IorD, memRead, memWrite, MemtoReg, IRWrite;
    logic       PCSource, ALUSrcA, regWrite, illegal_op;
    logic [1:0] ALUSrcB;
    logic [3:0] ALUControl;
    logic [3:0] state;

    // directed stimulus vs. datapath-driven stimulus
    logic       dp_mode;
    logic [6:0] dir_opcode;
    logic [2:0] dir_funct3;
    logic       dir_funct7b5;
    logic       dir_zero;

    // small reference datapath
    logic [31:0] pc, ir, a, b, aluout, mdr;
    logic [31:0] mem [0:63];
    logic [31:0] rf  [0:31];
    logic [31:0] addr, rdata, srca, srcb, imm, alu_y;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .PCWrite    (PCWrite),
        .IorD       (IorD),
        .memRead    (memRead),
        .memWrite   (memWrite),
        .MemtoReg   (MemtoReg),
        .IRWrite    (IRWrite),
        .PCSource   (PCSource),
        .ALUSrcA    (ALUSrcA),
        .regWrite   (regWrite),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .illegal_op (illegal_op),
        .state      (state)
    );

    assign opcode   = dp_mode ? ir[6:0]   : dir_opcode;
    assign funct3   = dp_mode ? ir[14:12] : dir_funct3;
    assign funct7b5 = dp_mode ? ir[30]    : dir_funct7b5;
    assign zero     = dp_mode ? (alu_y == 32'd0) : dir_zero;

    logic [15:0] ctl;
    assign ctl = {PCWrite, IorD, memRead, memWrite, MemtoReg, IRWrite, PCSource,
                  ALUSrcA, regWrite, ALUSrcB, ALUControl, illegal_op};

    function automatic logic [15:0] cw(input logic pcw, iord, mr, mw, m2r, irw, pcs, asa, rw,
                                       input logic [1:0] asb, input logic [3:0] aluc,
                                       input logic ill);
        return {pcw, iord, mr, mw, m2r, irw, pcs, asa, rw, asb, aluc, ill};
    endfunction

    // ---------------- instruction encoders and program image -------------
    function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {im, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_beq(input logic [4:0] rs2, rs1, input logic [12:0] im);
        return {im[12], im[10:5], rs2, rs1, 3'b000, im[4:1], im[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] prog_word(input int unsigned idx);
        case (idx)
            0:  return enc_i(12'd20, 5'd0, 3'b000, 5'd3, 7'b0010011);   // addi x3,x0,20
            1:  return enc_i(12'd120, 5'd3, 3'b010, 5'd8, 7'b0000011);  // lw x8,120(x3)
            2:  return enc_r(7'h00, 5'd8, 5'd3, 3'b000, 5'd10);         // add x10,x3,x8
            3:  return enc_r(7'h20, 5'd8, 5'd10, 3'b000, 5'd11);        // sub x11,x10,x8
            4:  return enc_beq(5'd11, 5'd3, 13'd8);                     // beq x3,x11,+8
            5:  return enc_r(7'h00, 5'd3, 5'd8, 3'b111, 5'd13);         // and x13,x8,x3
            6:  return enc_r(7'h00, 5'd3, 5'd8, 3'b110, 5'd14);         // or x14,x8,x3
            35: return 32'd82;                                          // mem[140]
            default: return 32'd0;
        endcase
    endfunction

    always_comb begin
        addr  = IorD ? aluout : pc;
        rdata = mem[addr[7:2]];
        case (ir[6:0])
            7'b0100011: imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            7'b1100011: imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            default:    imm = {{20{ir[31]}}, ir[31:20]};
        endcase
        srca = ALUSrcA ? a : pc;
        case (ALUSrcB)
            2'b00:   srcb = b;
            2'b01:   srcb = 32'd4;
            default: srcb = imm;
        endcase
        case (ALUControl)
            4'b0000: alu_y = srca & srcb;
            4'b0001: alu_y = srca | srcb;
            4'b0110: alu_y = srca - srcb;
            default: alu_y = srca + srcb;
        endcase
    end

    always @(posedge clk) begin
        if (dp_mode) begin
            if (reset) begin
                pc <= '0; ir <= '0; a <= '0; b <= '0; aluout <= '0; mdr <= '0;
                for (int i = 0; i < 64; i++) mem[i] <= prog_word(i);
                for (int i = 0; i < 32; i++) rf[i] <= '0;
            end else begin
                if (PCWrite) pc <= PCSource ? aluout : alu_y;
                if (IRWrite) ir <= rdata;
                mdr    <= rdata;
                a      <= rf[ir[19:15]];
                b      <= rf[ir[24:20]];
                aluout <= alu_y;
                if (memWrite) mem[aluout[7:2]] <= b;
                if (regWrite && ir[11:7] != 5'd0) rf[ir[11:7]] <= MemtoReg ? mdr : aluout;
            end
        end
    end

    // ---------------- checking ---------------------------------------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Check state and control word for the current cycle, then advance.
    task automatic step(input string tag, input logic [3:0] es, input logic [15:0] ew);
        #1;
        chk({tag, "_st"}, 32'(state), 32'(es));
        chk({tag, "_cw"}, 32'(ctl), 32'(ew));
        @(negedge clk);
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7b5,
                             input logic z);
        dir_opcode   = op;
        dir_funct3   = f3;
        dir_funct7b5 = f7b5;
        dir_zero     = z;
    endtask

    // expected control words, per state
    logic [15:0] W_RST, W_F, W_D, W_DILL, W_MA, W_MR, W_MWB, W_MW, W_XI, W_AWB, W_AWB_NR, W_PI;

    int ncyc;
    int pcw_cnt;
    int rw_cnt;
    int mw_cnt;
    logic done;

    initial begin
        W_RST    = cw(0,0,0,0,0,0,0,0,0, 2'b00, ADD, 0);
        W_F      = cw(0,0,1,0,0,1,0,0,0, 2'b00, ADD, 0);
        W_D      = cw(0,0,0,0,0,0,0,0,0, 2'b10, ADD, 0);
        W_DILL   = cw(0,0,0,0,0,0,0,0,0, 2'b10, ADD, 1);
        W_MA     = cw(0,0,0,0,0,0,0,1,0, 2'b10, ADD, 0);
        W_MR     = cw(0,1,1,0,0,0,0,0,0, 2'b00, ADD, 0);
        W_MWB    = cw(1,0,0,0,1,0,0,0,1, 2'b01, ADD, 0);
        W_MW     = cw(1,1,0,1,0,0,0,0,0, 2'b01, ADD, 0);
        W_XI     = cw(0,0,0,0,0,0,0,1,0, 2'b10, ADD, 0);
        W_AWB    = cw(1,0,0,0,0,0,0,0,1, 2'b01, ADD, 0);
        W_AWB_NR = cw(1,0,0,0,0,0,0,0,0, 2'b01, ADD, 0);
        W_PI     = cw(1,0,0,0,0,0,0,0,0, 2'b01, ADD, 0);

        dp_mode = 1'b0;
        reset   = 1'b1;
        set_instr(7'b0000000, 3'b000, 1'b0, 1'b0);

        // reset held three cycles
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("rst_st", 32'(state), 32'd0);
            chk("rst_cw", 32'(ctl), 32'(W_RST));
        end
        reset = 1'b0;

        // lw
        set_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
        step("lw0", 4'd0, W_F);  step("lw1", 4'd1, W_D);  step("lw2", 4'd2, W_MA);
        step("lw3", 4'd3, W_MR); step("lw4", 4'd4, W_MWB);
        // sw
        set_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
        step("sw0", 4'd0, W_F);  step("sw1", 4'd1, W_D);  step("sw2", 4'd2, W_MA);
        step("sw3", 4'd5, W_MW);
        // add
        set_instr(7'b0110011, 3'b000, 1'b0, 1'b0);
        step("add0", 4'd0, W_F); step("add1", 4'd1, W_D);
        step("add2", 4'd6, cw(0,0,0,0,0,0,0,1,0, 2'b00, ADD, 0));
        step("add3", 4'd8, W_AWB);
        // sub
        set_instr(7'b0110011, 3'b000, 1'b1, 1'b0);
        step("sub0", 4'd0, W_F); step("sub1", 4'd1, W_D);
        step("sub2", 4'd6, cw(0,0,0,0,0,0,0,1,0, 2'b00, SUB, 0));
        step("sub3", 4'd8, W_AWB);
        // and (funct7b5 don't-care)
        set_instr(7'b0110011, 3'b111, 1'b1, 1'b0);
        step("and0", 4'd0, W_F); step("and1", 4'd1, W_D);
        step("and2", 4'd6, cw(0,0,0,0,0,0,0,1,0, 2'b00, AND, 0));
        step("and3", 4'd8, W_AWB);
        // or
        set_instr(7'b0110011, 3'b110, 1'b0, 1'b0);
        step("or0", 4'd0, W_F);  step("or1", 4'd1, W_D);
        step("or2", 4'd6, cw(0,0,0,0,0,0,0,1,0, 2'b00, OR, 0));
        step("or3", 4'd8, W_AWB);
        // unsupported funct 0_101
        set_instr(7'b0110011, 3'b101, 1'b0, 1'b0);
        step("rbad0", 4'd0, W_F); step("rbad1", 4'd1, W_D);
        step("rbad2", 4'd6, cw(0,0,0,0,0,0,0,1,0, 2'b00, ADD, 1));
        step("rbad3", 4'd8, W_AWB_NR);
        // addi right after: register write must be back
        set_instr(7'b0010011, 3'b000, 1'b0, 1'b0);
        step("addi0", 4'd0, W_F); step("addi1", 4'd1, W_D); step("addi2", 4'd7, W_XI);
        step("addi3", 4'd8, W_AWB);
        // beq taken
        set_instr(7'b1100011, 3'b000, 1'b0, 1'b1);
        step("beqt0", 4'd0, W_F); step("beqt1", 4'd1, W_D);
        step("beqt2", 4'd9, cw(1,0,0,0,0,0,1,1,0, 2'b00, SUB, 0));
        // beq not taken
        set_instr(7'b1100011, 3'b000, 1'b0, 1'b0);
        step("beqn0", 4'd0, W_F); step("beqn1", 4'd1, W_D);
        step("beqn2", 4'd9, cw(0,0,0,0,0,0,1,1,0, 2'b00, SUB, 0));
        step("beqn3", 4'd10, W_PI);
        // illegal opcode
        set_instr(7'b1111111, 3'b000, 1'b0, 1'b0);
        step("ill0", 4'd0, W_F); step("ill1", 4'd1, W_DILL); step("ill2", 4'd10, W_PI);
        // lw abandoned by reset in MEM_READ
        set_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
        step("mrst0", 4'd0, W_F); step("mrst1", 4'd1, W_D); step("mrst2", 4'd2, W_MA);
        reset = 1'b1;
        step("mrst3", 4'd3, cw(0,1,0,0,0,0,0,0,0, 2'b00, ADD, 0));
        step("mrst4", 4'd0, W_RST);
        reset = 1'b0;
        step("mrst5", 4'd0, W_F);

        // program run through the reference datapath
        dp_mode = 1'b1;
        reset   = 1'b1;
        repeat (2) @(negedge clk);
        reset   = 1'b0;
        done    = 1'b0;
        ncyc    = 0;
        pcw_cnt = 0;
        rw_cnt  = 0;
        mw_cnt  = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            ncyc = i + 1;
            if (pc == 32'd28 && state == 4'd0) begin
                done = 1'b1;
                break;
            end
            if (PCWrite)  pcw_cnt++;
            if (regWrite) rw_cnt++;
            if (memWrite) mw_cnt++;
        end
        chk("dp_done",   32'(done), 32'd1);
        chk("dp_cycles", 32'(ncyc), 32'd24);
        chk("dp_pcw",    32'(pcw_cnt), 32'd6);
        chk("dp_rw",     32'(rw_cnt), 32'd5);
        chk("dp_mw",     32'(mw_cnt), 32'd0);
        chk("x3",  rf[3],  32'd20);
        chk("x8",  rf[8],  32'd82);
        chk("x10", rf[10], 32'd102);
        chk("x11", rf[11], 32'd20);
        chk("x13", rf[13], 32'd0);
        chk("x14", rf[14], 32'd86);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
